// File: rtl/bist_sig_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bist_sig_analyzer                                          |
// | Description : BIST output-response analyzer. Compacts W-bit responses    |
// |               into a MISR, counts accepted responses and, after          |
// |               N_PATTERNS of them, compares the signature against GOLDEN. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bist_sig_analyzer #(
  parameter int             W          = 5,
  parameter logic [W-1:0]   POLY       = 5'b00101,
  parameter int             N_PATTERNS = 31,
  parameter int             CNT_W      = 6,
  parameter logic [W-1:0]   GOLDEN     = 5'b00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [W-1:0]     resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [W-1:0]     signature,
  output logic [CNT_W-1:0] count
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_PATTERNS);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [W-1:0]     r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;

  logic [W-1:0]     w_fb;
  logic [W-1:0]     w_next_sig;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;

  // MISR next value: shift left, fold the outgoing MSB back through POLY, mix in the response
  always_comb begin
    w_fb       = r_sig[W-1] ? POLY : '0;
    w_next_sig = {r_sig[W-2:0], 1'b0} ^ w_fb ^ resp_in;
    w_cnt_inc  = r_cnt + c_ONE;
    w_last     = (w_cnt_inc == c_LAST);
  end

  // Session FSM with signature, counter and verdict registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          // A response arriving with start belongs to no session and is dropped
          if (start) begin
            r_state <= c_RUN;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
          end
        end
        c_RUN: begin
          if (resp_valid) begin
            r_sig <= w_next_sig;
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_state <= c_DONE;
              r_pass  <= (w_next_sig == GOLDEN);
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (r_state == c_RUN);
  assign done      = (r_state == c_DONE);
  assign pass      = r_pass;
  assign signature = r_sig;
  assign count     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bist_sig_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bist_sig_analyzer                                       |
// | Description : Self-checking bench for bist_sig_analyzer. Four instances  |
// |               with different session lengths/goldens share one stimulus  |
// |               stream; session verdicts go through a scoreboard queue.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bist_sig_analyzer;

  logic            clk;
  logic            rst;
  logic            start;
  logic            resp_valid;
  logic [4:0]      resp_in;
  logic [3:0]      busy;
  logic [3:0]      done;
  logic [3:0]      pass;
  logic [3:0][4:0] sig;
  logic [3:0][5:0] cnt;

  int n_total = 0;
  int n_bad   = 0;

  // Per-instance session length and golden signature
  int         NP   [4] = '{4, 6, 31, 1};
  logic [4:0] GOLD [4] = '{5'b01111, 5'b00000, 5'b00000, 5'b10101};

  bist_sig_analyzer #(.W(5), .POLY(5'b00101), .N_PATTERNS(4), .CNT_W(6), .GOLDEN(5'b01111)) u0 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp_in(resp_in),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]), .count(cnt[0]));
  bist_sig_analyzer #(.W(5), .POLY(5'b00101), .N_PATTERNS(6), .CNT_W(6), .GOLDEN(5'b00000)) u1 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp_in(resp_in),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]), .count(cnt[1]));
  bist_sig_analyzer #(.W(5), .POLY(5'b00101), .N_PATTERNS(31), .CNT_W(6), .GOLDEN(5'b00000)) u2 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp_in(resp_in),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]), .count(cnt[2]));
  bist_sig_analyzer #(.W(5), .POLY(5'b00101), .N_PATTERNS(1), .CNT_W(6), .GOLDEN(5'b10101)) u3 (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp_in(resp_in),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]), .count(cnt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: session mode plus the list of accepted responses
  int         m_mode [4];   // 0 idle, 1 running, 2 finished
  int         m_n    [4];
  bit         m_pass [4];
  logic [4:0] m_resp [4][64];

  typedef struct {
    int         id;
    logic [4:0] s;
    bit         p;
    int         c;
  } res_t;
  res_t exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Multiply by x modulo x^5 + x^2 + 1 over GF(2)
  function automatic logic [4:0] mulx(input logic [4:0] a);
    logic [5:0] t;
    t = {a, 1'b0};
    if (t[5]) t = t ^ 6'b100101;
    return t[4:0];
  endfunction

  // Signature = sum of r_k * x^(n-1-k) mod p, evaluated by Horner's rule
  function automatic logic [4:0] sig_of(input int i);
    logic [4:0] a;
    a = 5'd0;
    for (int k = 0; k < m_n[i]; k++) a = mulx(a) ^ m_resp[i][k];
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0;
      m_n[i]    = 0;
      m_pass[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit st, input bit v, input logic [4:0] d);
    res_t r;
    for (int i = 0; i < 4; i++) begin
      if (m_mode[i] != 1) begin
        if (st) begin
          m_mode[i] = 1;
          m_n[i]    = 0;
          m_pass[i] = 1'b0;
        end
      end else if (v) begin
        m_resp[i][m_n[i]] = d;
        m_n[i]++;
        if (m_n[i] == NP[i]) begin
          m_mode[i] = 2;
          r.id = i;
          r.s  = sig_of(i);
          r.p  = (r.s == GOLD[i]);
          r.c  = m_n[i];
          m_pass[i] = r.p;
          exp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic chk_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy[%0d]", i),  int'(busy[i]), int'(m_mode[i] == 1));
      chk($sformatf("done[%0d]", i),  int'(done[i]), int'(m_mode[i] == 2));
      chk($sformatf("pass[%0d]", i),  int'(pass[i]), int'(m_mode[i] == 2 && m_pass[i]));
      chk($sformatf("sig[%0d]", i),   int'(sig[i]),  int'(sig_of(i)));
      chk($sformatf("count[%0d]", i), int'(cnt[i]),  m_n[i]);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic cyc(input bit st, input bit v, input logic [4:0] d);
    start      = st;
    resp_valid = v;
    resp_in    = d;
    model_step(st, v, d);
    @(posedge clk);
    #1;
    chk_all();
  endtask

  // Reset asserted between edges (after the monitor's negedge), held two edges
  task automatic reset_mid();
    #6;
    rst = 1'b0;
    #1;
    model_reset();
    chk_all();
    repeat (2) begin
      start      = 1'($urandom_range(0, 1));
      resp_valid = 1'($urandom_range(0, 1));
      resp_in    = 5'($urandom);
      @(posedge clk);
      #1;
      chk_all();
    end
    rst        = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;
  endtask

  // Scoreboard monitor: on each rising done, pop the expected session result
  bit   [3:0] prev_done = 4'b0;
  always @(negedge clk) begin
    res_t e;
    for (int i = 0; i < 4; i++) begin
      if (done[i] && !prev_done[i]) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("sb_unexpected_done[%0d]", i), 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("sb_id[%0d]", i),    i,              e.id);
          chk($sformatf("sb_sig[%0d]", i),   int'(sig[i]),   int'(e.s));
          chk($sformatf("sb_pass[%0d]", i),  int'(pass[i]),  int'(e.p));
          chk($sformatf("sb_count[%0d]", i), int'(cnt[i]),   e.c);
        end
      end
    end
    prev_done <= done;
  end

  logic [4:0] steps [4] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111};

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_in    = 5'd0;
    model_reset();

    // Reset held with random inputs
    repeat (2) begin
      start      = 1'($urandom_range(0, 1));
      resp_valid = 1'($urandom_range(0, 1));
      resp_in    = 5'($urandom);
      @(posedge clk);
      #1;
      chk_all();
    end
    rst        = 1'b1;
    start      = 1'b0;
    resp_valid = 1'b0;

    // Responses in IDLE and alongside start are not absorbed
    cyc(1'b0, 1'b1, 5'($urandom));
    cyc(1'b0, 1'b1, 5'($urandom));
    chk("idle_sig", int'(sig[0]), 0);
    cyc(1'b1, 1'b1, 5'b10110);
    chk("start_sig", int'(sig[0]), 0);
    chk("start_busy", int'(busy[0]), 1);

    // Back-to-back absorb of 00001
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 5'b00001);
      chk($sformatf("step_sig%0d", k), int'(sig[0]), int'(steps[k]));
    end
    chk("n4_done", int'(done[0]), 1);
    chk("n4_pass", int'(pass[0]), 1);
    chk("n4_count", int'(cnt[0]), 4);
    chk("n1_done", int'(done[3]), 1);
    chk("n1_pass", int'(pass[3]), 0);

    // Polynomial feedback on the 6-response instance
    cyc(1'b0, 1'b1, 5'b00001);
    chk("n6_sig5", int'(sig[1]), int'(5'b11111));
    cyc(1'b0, 1'b1, 5'b00001);
    chk("n6_sig6", int'(sig[1]), int'(5'b11010));
    chk("n6_done", int'(done[1]), 1);
    chk("n6_pass", int'(pass[1]), 0);
    chk("n4_frozen", int'(sig[0]), int'(5'b01111));

    // Restart from DONE
    cyc(1'b1, 1'b0, 5'd0);
    chk("rs_done", int'(done[0]), 0);
    chk("rs_pass", int'(pass[0]), 0);
    chk("rs_sig", int'(sig[0]), 0);
    chk("rs_count", int'(cnt[0]), 0);

    // Gapped responses with a start pulse mid-run
    for (int k = 0; k < 8; k++)
      cyc(k == 3, (k % 2) == 0, (k % 2) == 0 ? 5'b00001 : 5'($urandom));
    chk("gap_sig", int'(sig[0]), int'(5'b01111));
    chk("gap_pass", int'(pass[0]), 1);
    chk("gap_done", int'(done[0]), 1);

    // Mid-session reset after two accepted responses
    cyc(1'b1, 1'b0, 5'd0);
    cyc(1'b0, 1'b1, 5'($urandom));
    cyc(1'b0, 1'b1, 5'($urandom));
    chk("pre_rst_count", int'(cnt[0]), 2);
    reset_mid();
    chk("post_rst_busy", int'(busy[0]), 0);
    repeat (3) cyc(1'b0, 1'b1, 5'($urandom));
    chk("post_rst_sig", int'(sig[0]), 0);
    chk("post_rst_count", int'(cnt[0]), 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0)
        reset_mid();
      else
        cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 5'($urandom));
    end

    repeat (3) cyc(1'b0, 1'b0, 5'd0);
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
